// File: rtl/md_sched.sv
// md_sched: HI/LO multiply/divide scheduler with D-stage stall generation
module md_sched #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  md_op_E,
    input  logic [31:0] rs_E,
    input  logic [31:0] rt_E,
    input  logic        md_use_D,
    input  logic        stall_reg,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        en_pc,
    output logic        en12,
    output logic        clr23
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d, shi_q, shi_d, slo_q, slo_d;
    logic [63:0] prod_s, prod_u, res;
    logic [31:0] quo_s, rem_s, quo_u, rem_u;
    logic        md_start, is_mul, md_stall, stall;

    assign md_start = (md_op_E != 3'd0) && (md_op_E <= 3'd4);
    assign is_mul   = (md_op_E == 3'd1) || (md_op_E == 3'd2);

    // full 64-bit result for the op in E; a zero divisor keeps current HI/LO
    always_comb begin
        prod_s = $signed({{32{rs_E[31]}}, rs_E}) * $signed({{32{rt_E[31]}}, rt_E});
        prod_u = {32'd0, rs_E} * {32'd0, rt_E};
        quo_s  = $signed(rs_E) / $signed(rt_E);
        rem_s  = $signed(rs_E) % $signed(rt_E);
        quo_u  = rs_E / rt_E;
        rem_u  = rs_E % rt_E;
        res    = is_mul ? ((md_op_E == 3'd1) ? prod_s : prod_u) :
                 (rt_E == 32'd0) ? {hi_q, lo_q} :
                 (md_op_E == 3'd3) ? {rem_s, quo_s} : {rem_u, quo_u};
    end

    // next-state: start/mthi/mtlo in IDLE, countdown and commit in BUSY
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        shi_d   = shi_q;
        slo_d   = slo_q;
        if (state_q == IDLE) begin
            if (md_start) begin
                state_d      = BUSY;
                cnt_d        = is_mul ? 4'(MULT_CYC) : 4'(DIV_CYC);
                {shi_d, slo_d} = res;
            end else begin
                hi_d = (md_op_E == 3'd5) ? rs_E : hi_q;
                lo_d = (md_op_E == 3'd6) ? rs_E : lo_q;
            end
        end else begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                state_d = IDLE;
                hi_d    = shi_q;
                lo_d    = slo_q;
            end
        end
    end

    // state and data registers, async active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            shi_q   <= '0;
            slo_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            shi_q   <= shi_d;
            slo_q   <= slo_d;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = (state_q == BUSY);
    assign md_stall = reset & md_use_D & (busy | md_start);
    assign stall    = md_stall | stall_reg;
    assign en_pc    = ~stall;
    assign en12     = ~stall;
    assign clr23    = stall;
endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: directed literal checks plus randomized run against a behavioural HI/LO model
module tb_md_sched;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  md_op_E = '0;
    logic [31:0] rs_E = '0;
    logic [31:0] rt_E = '0;
    logic        md_use_D = 1'b0;
    logic        stall_reg = 1'b0;
    logic [31:0] hi, lo;
    logic        busy, en_pc, en12, clr23;

    int checks = 0;
    int errors = 0;

    md_sched #(.MULT_CYC(MC), .DIV_CYC(DC)) dut (
        .clk(clk), .reset(reset), .md_op_E(md_op_E), .rs_E(rs_E), .rt_E(rt_E),
        .md_use_D(md_use_D), .stall_reg(stall_reg), .hi(hi), .lo(lo),
        .busy(busy), .en_pc(en_pc), .en12(en12), .clr23(clr23)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // behavioural model: architectural HI/LO, remaining busy cycles, pending result
    logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
    int          m_rem = 0;
    bit          m_wr = 1'b0;

    always @(posedge clk or negedge reset) begin
        logic [63:0] p;
        longint      sa, sb, q, r;
        if (!reset) begin
            m_hi = '0; m_lo = '0; m_rem = 0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0 && m_wr) begin
                m_hi = m_phi; m_lo = m_plo;
            end
        end else begin
            sa = longint'($signed(rs_E));
            sb = longint'($signed(rt_E));
            case (md_op_E)
                3'd1: begin p = 64'(sa * sb); m_phi = p[63:32]; m_plo = p[31:0]; m_wr = 1; m_rem = MC; end
                3'd2: begin p = {32'd0, rs_E} * {32'd0, rt_E}; m_phi = p[63:32]; m_plo = p[31:0]; m_wr = 1; m_rem = MC; end
                3'd3: begin
                    m_wr = (rt_E != 0); m_rem = DC;
                    if (m_wr) begin
                        q = sa / sb; r = sa % sb;
                        p = 64'(q); m_plo = p[31:0];
                        p = 64'(r); m_phi = p[31:0];
                    end
                end
                3'd4: begin
                    m_wr = (rt_E != 0); m_rem = DC;
                    if (m_wr) begin m_plo = rs_E / rt_E; m_phi = rs_E % rt_E; end
                end
                3'd5: m_hi = rs_E;
                3'd6: m_lo = rs_E;
                default: ;
            endcase
        end
    end

    // every-cycle comparison of all outputs against the model
    bit chk_on = 1'b1;
    always @(negedge clk) begin
        logic e_stall;
        if (chk_on) begin
            e_stall = stall_reg | (reset & md_use_D & ((m_rem > 0) || (md_op_E >= 3'd1 && md_op_E <= 3'd4)));
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
            chk("busy", 32'(busy), 32'(m_rem > 0));
            chk("en_pc", 32'(en_pc), 32'(!e_stall));
            chk("en12", 32'(en12), 32'(!e_stall));
            chk("clr23", 32'(clr23), 32'(e_stall));
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    // issue one op and count busy cycles and stall cycles until busy falls
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic use_d, output int nb, output int ns);
        step();
        md_op_E = op; rs_E = a; rt_E = b; md_use_D = use_d;
        #1 ns = int'(clr23);
        step();
        md_op_E = 3'd0;
        nb = 0;
        while (busy && nb < 20) begin
            nb++;
            ns += int'(clr23);
            step();
        end
        md_use_D = 1'b0;
    endtask

    initial begin
        int nb, ns;
        logic [31:0] lo_prev;
        repeat (3) step();
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        md_op_E = 3'd1; md_use_D = 1'b1; stall_reg = 1'b1;
        #1 chk("rst_clr23_sreg", 32'(clr23), 32'h1);
        chk("rst_en_pc_sreg", 32'(en_pc), 32'h0);
        stall_reg = 1'b0;
        #1 chk("rst_clr23_forced", 32'(clr23), 32'h0);
        chk("rst_en12_forced", 32'(en12), 32'h1);
        md_op_E = 3'd0; md_use_D = 1'b0;
        step();
        reset = 1'b1;

        run_op(3'd1, 32'hFFFFFFFF, 32'd2, 1'b0, nb, ns);
        chk("mult_busy", 32'(nb), 32'd5);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFFE);

        run_op(3'd2, 32'hFFFFFFFF, 32'd2, 1'b0, nb, ns);
        chk("multu_busy", 32'(nb), 32'd5);
        chk("multu_hi", hi, 32'h00000001);
        chk("multu_lo", lo, 32'hFFFFFFFE);

        run_op(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0, nb, ns);
        chk("div_busy", 32'(nb), 32'd10);
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);

        run_op(3'd4, 32'd7, 32'd2, 1'b0, nb, ns);
        chk("divu_lo", lo, 32'd3);
        chk("divu_hi", hi, 32'd1);

        step();
        md_op_E = 3'd5; rs_E = 32'h12345678;
        step();
        md_op_E = 3'd0;
        chk("mthi_hi", hi, 32'h12345678);
        chk("mthi_lo_kept", lo, 32'd3);
        lo_prev = lo;
        run_op(3'd3, 32'd99, 32'd0, 1'b0, nb, ns);
        chk("div0_busy", 32'(nb), 32'd10);
        chk("div0_hi", hi, 32'h12345678);
        chk("div0_lo", lo, lo_prev);

        run_op(3'd1, 32'd6, 32'd7, 1'b1, nb, ns);
        chk("mflo_stall_cycles", 32'(ns), 32'd6);
        chk("mflo_new_lo", lo, 32'd42);

        step();
        md_op_E = 3'd3; rs_E = 32'd100; rt_E = 32'd3;
        step();
        md_op_E = 3'd0;
        step();
        step();
        reset = 1'b0;
        #1 chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
        stall_reg = 1'b1;
        #1 chk("abort_clr23", 32'(clr23), 32'h1);
        step();
        stall_reg = 1'b0;
        reset = 1'b1;
        repeat (12) step();
        chk("abort_no_commit_lo", lo, 32'h0);
        chk("abort_no_commit_hi", hi, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            int sel;
            step();
            reset = ($urandom_range(0, 299) != 0);
            md_op_E = ($urandom_range(0, 9) < 5) ? 3'd0 : 3'($urandom_range(1, 7));
            rs_E = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            sel = $urandom_range(0, 5);
            rt_E = (sel == 0) ? 32'd0 : (sel == 1) ? 32'($urandom_range(1, 9)) :
                   (sel == 2) ? 32'hFFFFFFFF : $urandom;
            if (md_op_E == 3'd3 && rs_E == 32'h80000000 && rt_E == 32'hFFFFFFFF) rt_E = 32'd1;
            md_use_D = 1'($urandom_range(0, 1));
            stall_reg = ($urandom_range(0, 4) == 0);
        end
        step();
        reset = 1'b1; md_op_E = 3'd0;
        repeat (20) step();
        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
